vga_sync_decoder: RTL
=====================

// Module: vga_sync_decoder
// PURPOSE
//   Receive-side counterpart of the VGA timing generator. Samples external active-low
//   hsync/vsync and recovers pixel/line coordinates. Measures line period, hsync width
//   and lines per frame, and reports lock once the timing has been stable for
//   LOCK_FRAMES frames. Used to validate generator output and to drive capture logic.
// PARAMETERS
//   XW          12  width of pixel_x, line_period, hsync_width (clocks)
//   YW          11  width of pixel_y, frame_lines (lines)
//   LINE_TOL     1  max |line_period - previous line_period| tolerated while measuring/locked
//   LOCK_FRAMES  2  consecutive matching frames required to assert locked
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   rst_n        in   1   synchronous reset, active low
//   hsync_n_in   in   1   async horizontal sync, active low
//   vsync_n_in   in   1   async vertical sync, active low
//   pixel_x      out  XW  clocks since last line start; saturates at 2^XW-1
//   pixel_y      out  YW  lines since frame start; saturates at 2^YW-1
//   line_start   out  1   1-clk pulse, registered hsync falling edge
//   frame_start  out  1   1-clk pulse, coincident with first line_start at/after vsync fall
//   line_period  out  XW  clocks between the last two line starts
//   hsync_width  out  XW  low time of the last completed hsync pulse
//   frame_lines  out  YW  line starts in the last completed frame
//   locked       out  1   high only in state LOCKED
//   lock_lost    out  1   1-clk pulse on any LOCKED -> non-LOCKED transition
// BEHAVIOUR
//   Reset: all outputs 0, FSM = SEARCH, synchronizers and edge registers set to 1 (idle high).
//   Input path: 2-flop synchronizer per sync, then previous-value register.
//     Input low first sampled at edge k -> line_start high during cycle after edge k+3.
//   Edge rules:
//     - vsync fall sets vs_pending; vsync and hsync falling together also set it.
//     - line_start with vs_pending (set this cycle or earlier) -> frame_start=1, pending cleared.
//   Counters:
//     - pixel_x <= 0 on line_start, else +1 saturating.
//     - pixel_y <= 0 on frame_start, +1 saturating on other line_starts.
//   Measurement (latched on the event; value available the cycle after the pulse):
//     - line_period <= pixel_x+1 on line_start.
//     - hsync_width <= clocks low, latched on hsync rising edge.
//     - frame_lines <= pixel_y+1 on frame_start.
//   FSM (state, match_cnt, line_err flag):
//     SEARCH : on frame_start -> MEASURE, match_cnt=0, line_err=0.
//     MEASURE: line_start with |new period - old period| > LINE_TOL sets line_err.
//              On frame_start: if new frame_lines == old frame_lines and !line_err,
//              match_cnt++, else match_cnt=0. Clear line_err.
//              match_cnt reaching LOCK_FRAMES -> LOCKED.
//     LOCKED : line period outside tolerance, or frame_lines mismatch at frame_start
//              -> MEASURE, match_cnt=0, lock_lost=1.
//     Any state: pixel_x reaching 2^XW-1 (hsync timeout) -> SEARCH.
//              Pulse lock_lost if leaving LOCKED.
//   locked and lock_lost change the cycle after the causing line_start/frame_start or timeout.
//   Reset mid-frame or mid-lock takes priority over all events and returns to reset values.
// TESTING
//   1 rst_n=0 with toggling syncs -> all outputs 0; after release, no pulses until an edge.
//   2 Stream: 768 clk/line, hsync low 16 clk, 512 lines, vsync low line 0.
//     -> line_period=768, hsync_width=16, frame_lines=512.
//     -> locked rises after the 4th frame_start (LOCK_FRAMES=2).
//   3 Locked, one line at 769 clk -> stays locked.
//     Locked, one line at 771 clk -> locked=0 and lock_lost pulse the cycle after that
//     line_start; relocks 3 frames later.
//   4 Locked, hsync held high -> at pixel_x=4095: locked=0, lock_lost=1, FSM SEARCH;
//     pixel_x holds 4095.
//   5 vsync falls 5 clk before hsync -> frame_start and pixel_y=0 at that hsync's
//     line_start, not earlier.
//   6 rst_n low for 1 clk mid-frame while locked -> outputs 0.
//     Relock follows the same sequence as scenario 2.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: synchronizes active-low hsync/vsync, recovers
// pixel/line coordinates, measures line/hsync/frame timing and tracks lock.

module vga_sync_in (
  input  logic clk,
  input  logic rst_n,
  input  logic syncN,
  output logic cur,
  output logic prev
);
  // sh[1:0] synchronize, sh[2] is the sampled level, sh[3] its previous value
  logic [3:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) sh <= '1;
    else        sh <= {sh[2:0], syncN};
  end

  assign cur  = sh[2];
  assign prev = sh[3];
endmodule

module vga_sync_decoder #(
  parameter int XW          = 12,
  parameter int YW          = 11,
  parameter int LINE_TOL    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync_n_in,
  input  logic          vsync_n_in,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [XW-1:0] line_period,
  output logic [XW-1:0] hsync_width,
  output logic [YW-1:0] frame_lines,
  output logic          locked,
  output logic          lock_lost
);
  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t        state;
  logic [CW-1:0] matchCnt;
  logic          lineErr;
  logic          vsPending;
  logic          hRiseR;

  logic [1:0] syncIn, cur, prev;
  assign syncIn = {vsync_n_in, hsync_n_in};

  for (genvar i = 0; i < 2; i++) begin : gSync
    vga_sync_in uSync (
      .clk  (clk),
      .rst_n(rst_n),
      .syncN(syncIn[i]),
      .cur  (cur[i]),
      .prev (prev[i])
    );
  end

  logic hFall, hRise, vFall;
  assign hFall = prev[0] & ~cur[0];
  assign hRise = ~prev[0] & cur[0];
  assign vFall = prev[1] & ~cur[1];

  logic [XW-1:0] xInc, pDiff;
  logic [YW-1:0] yInc;
  logic [CW-1:0] matchNext;
  logic          periodBad, linesMatch;

  assign xInc       = (pixel_x == XMAX) ? XMAX : pixel_x + 1'b1;
  assign yInc       = (pixel_y == YMAX) ? YMAX : pixel_y + 1'b1;
  assign pDiff      = (xInc > line_period) ? xInc - line_period : line_period - xInc;
  assign periodBad  = pDiff > XW'(LINE_TOL);
  assign linesMatch = (yInc == frame_lines);
  assign matchNext  = matchCnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_period <= '0;
      hsync_width <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      state       <= SEARCH;
      matchCnt    <= '0;
      lineErr     <= 1'b0;
      vsPending   <= 1'b0;
      hRiseR      <= 1'b0;
    end else begin
      line_start  <= hFall;
      frame_start <= hFall & (vsPending | vFall);
      hRiseR      <= hRise;
      if (hFall)      vsPending <= 1'b0;
      else if (vFall) vsPending <= 1'b1;

      // measurements latch off the registered pulses, so they land a cycle later
      if (line_start) begin
        pixel_x     <= '0;
        line_period <= xInc;
      end else begin
        pixel_x <= xInc;
      end
      if (hRiseR) hsync_width <= xInc;
      if (frame_start) begin
        pixel_y     <= '0;
        frame_lines <= yInc;
      end else if (line_start) begin
        pixel_y <= yInc;
      end

      lock_lost <= 1'b0;
      // hsync timeout overrides every other event
      if (pixel_x == XMAX) begin
        if (state != SEARCH) begin
          state     <= SEARCH;
          matchCnt  <= '0;
          lineErr   <= 1'b0;
          locked    <= 1'b0;
          lock_lost <= (state == LOCKED);
        end
      end else begin
        case (state)
          SEARCH: begin
            if (frame_start) begin
              state    <= MEASURE;
              matchCnt <= '0;
              lineErr  <= 1'b0;
            end
          end
          MEASURE: begin
            if (frame_start) begin
              if (linesMatch && !lineErr && !periodBad) begin
                matchCnt <= matchNext;
                if (matchNext == CW'(LOCK_FRAMES)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                matchCnt <= '0;
              end
              lineErr <= 1'b0;
            end else if (line_start && periodBad) begin
              lineErr <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_start && (periodBad || (frame_start && !linesMatch))) begin
              state     <= MEASURE;
              matchCnt  <= '0;
              lineErr   <= 1'b0;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
